rca_seq_ctrl: RTL

//  Sequences one WORD_W-bit ripple-carry adder slice (fulladdR, instantiated outside this block)
//  to add NWORDS*WORD_W-bit operands, one slice per clock, LS slice first.

---
 rtl/rca_pkg.sv | 13 +
 rtl/fulladdR.sv | 21 ++
 rtl/rca_seq_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/rca_pkg.sv
// Shared definitions for the sequenced ripple-carry adder controller:
// the FSM state encoding and the default slice geometry.
package rca_pkg;

  localparam int unsigned WORD_W_DEF = 4;
  localparam int unsigned NWORDS_DEF = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/fulladdR.sv
// Combinational WIDTH-bit ripple-carry adder slice, driven one slice per clock
// by rca_seq_ctrl through its add_* ports.
module fulladdR #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] total;

  always_comb begin
    total = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    sum   = total[WIDTH-1:0];
    cout  = total[WIDTH];
  end

endmodule

// File: rtl/rca_seq_ctrl.sv
// Sequences an external WORD_W-bit adder slice over NWORDS slices, LS slice first.
// Optional feature: define RCA_SEQ_SUB_EN to add a "sub" input selecting a - b.
module rca_seq_ctrl
  import rca_pkg::*;
#(
  parameter int unsigned WORD_W = WORD_W_DEF,
  parameter int unsigned NWORDS = NWORDS_DEF,
  localparam int unsigned OPW   = WORD_W * NWORDS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [OPW-1:0]    a,
  input  logic [OPW-1:0]    b,
  input  logic              cin,
`ifdef RCA_SEQ_SUB_EN
  input  logic              sub,
`endif
  output logic              busy,
  output logic              done,
  output logic [OPW-1:0]    sum,
  output logic              cout,
  output logic [WORD_W-1:0] add_a,
  output logic [WORD_W-1:0] add_b,
  output logic              add_cin,
  input  logic [WORD_W-1:0] add_sum,
  input  logic              add_cout
);

  localparam int unsigned IW = $clog2(NWORDS);
  localparam logic [IW-1:0] LastIdx = IW'(NWORDS - 1);

  state_e         state_q, state_d;
  logic [OPW-1:0] a_q, a_d;
  logic [OPW-1:0] b_q, b_d;
  logic [OPW-1:0] sum_q, sum_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           carry_q, carry_d;
  logic           cout_q, cout_d;
  logic           done_q, done_d;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
`ifdef RCA_SEQ_SUB_EN
          // Two's complement: a + ~b + 1; cout=1 then means no borrow.
          if (sub) begin
            b_d     = ~b;
            carry_d = 1'b1;
          end
`endif
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Earlier slices of sum stay untouched; unwritten slices keep the old result.
        sum_d[idx_q*WORD_W +: WORD_W] = add_sum;
        carry_d = add_cout;
        if (idx_q == LastIdx) begin
          cout_d  = add_cout;
          done_d  = 1'b1;
          idx_d   = '0;
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

  // Adder inputs are gated to zero while idle so the slice sees no activity.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state_q == ST_RUN) begin
      add_a   = a_q[idx_q*WORD_W +: WORD_W];
      add_b   = b_q[idx_q*WORD_W +: WORD_W];
      add_cin = carry_q;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
